// File: rtl/bnn_roll_sched.sv
// ============================================================================
// Module  : bnn_roll_sched
// Brief   : Handshaked sequencer for a rolled BNN core: latches a sample,
//           pulses the core restart, waits out its latency, returns the class.
// Option  : BNN_ROLL_SCHED_PERF_EN enables the busy_cycles counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bnn_roll_sched #(
  parameter int FEAT_CNT   = 16,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 10,
  parameter int RUN_CYCLES = 2 * HIDDEN_CNT,
  parameter int TAG_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]  in_features,
  input  logic [TAG_BITS-1:0]            in_tag,
  output logic [FEAT_BITS*FEAT_CNT-1:0]  core_features,
  output logic                           core_rst,
  input  logic [$clog2(CLASS_CNT)-1:0]   core_prediction,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]   out_class,
  output logic [TAG_BITS-1:0]            out_tag,
  output logic                           out_err,
  output logic [15:0]                    done_cnt,
  output logic [31:0]                    busy_cycles
);

  localparam int               CLS_W       = $clog2(CLASS_CNT);
  localparam logic [15:0]      C_RUN_LOAD  = 16'(RUN_CYCLES - 1);
  localparam logic [CLS_W:0]   C_CLASS_LIM = (CLS_W + 1)'(CLASS_CNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          state_q;
  logic [15:0]                     cnt_q;
  logic [FEAT_BITS*FEAT_CNT-1:0]   feat_q;
  logic [TAG_BITS-1:0]             tag_q;
  logic [CLS_W-1:0]                out_class_q;
  logic [TAG_BITS-1:0]             out_tag_q;
  logic                            out_err_q;
  logic                            out_valid_q;
  logic                            core_rst_q;
  logic [15:0]                     done_cnt_q;
  logic                            accept;

  // Gated by rst so the source never sees ready while the block is held in reset.
  assign in_ready = (state_q == S_IDLE) && rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      feat_q      <= '0;
      tag_q       <= '0;
      out_class_q <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      core_rst_q  <= 1'b1;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          core_rst_q <= 1'b1;
          if (accept) begin
            feat_q  <= in_features;
            tag_q   <= in_tag;
            state_q <= S_START;
          end
        end
        S_START: begin
          core_rst_q <= 1'b0;
          cnt_q      <= C_RUN_LOAD;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          if (cnt_q == 16'd0) begin
            out_class_q <= core_prediction;
            out_tag_q   <= tag_q;
            out_err_q   <= ({1'b0, core_prediction} >= C_CLASS_LIM);
            out_valid_q <= 1'b1;
            done_cnt_q  <= done_cnt_q + 16'd1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DONE: begin
          // Core stays out of reset here so its prediction is not disturbed.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            core_rst_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_features = feat_q;
  assign core_rst      = core_rst_q;
  assign out_valid     = out_valid_q;
  assign out_class     = out_class_q;
  assign out_tag       = out_tag_q;
  assign out_err       = out_err_q;
  assign done_cnt      = done_cnt_q;

`ifdef BNN_ROLL_SCHED_PERF_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if ((state_q != S_IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
      busy_d = busy_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_cycles = busy_q;
`else
  assign busy_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bnn_roll_sched.sv
// ============================================================================
// Module  : tb_bnn_roll_sched
// Brief   : Scoreboard bench for bnn_roll_sched with a latency-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bnn_roll_sched;

  localparam int R   = 80;
  localparam int CLS = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_features = '0;
  logic [7:0]  in_tag = '0;
  logic [63:0] core_features;
  logic        core_rst;
  logic [3:0]  core_prediction = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_class;
  logic [7:0]  out_tag;
  logic        out_err;
  logic [15:0] done_cnt;
  logic [31:0] busy_cycles;

  typedef struct {
    logic [7:0]  tag;
    logic [3:0]  pred;
    logic [63:0] feat;
    int          acc;
  } item_t;

  item_t       q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  logic [15:0] done_m = '0;
  logic [31:0] busy_m = '0;
  logic        rnd_ready = 1'b0;
  logic        ready_fix = 1'b1;
  bit          act;
  int          k;

  bnn_roll_sched dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .in_tag(in_tag),
    .core_features(core_features), .core_rst(core_rst),
    .core_prediction(core_prediction),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_tag(out_tag), .out_err(out_err),
    .done_cnt(done_cnt), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
  end

  task automatic check(input string nm, input logic [79:0] act_v, input logic [79:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  // Model: a sample accepted at edge A is in START during cycle A, RUN for R
  // cycles, and presents its result from edge A+R+1 until the out handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_ctrl", 80'({in_ready, core_rst, out_valid, out_err}), 80'(4'b0100));
      check("reset_data", 80'({out_class, out_tag, core_features}), 80'(0));
      check("reset_counters", 80'({done_cnt, busy_cycles}), 80'(0));
      q.delete();
      done_m = '0;
      busy_m = '0;
    end else begin
      act = (q.size() > 0) && (cyc >= q[0].acc);
      k   = act ? (cyc - q[0].acc) : 0;
      check("in_ready", 80'(in_ready), 80'(!act));
      check("core_rst", 80'(core_rst), 80'(!act || (k == 0)));
      check("out_valid", 80'(out_valid), 80'(act && (k >= R + 1)));
      if (act) check("core_features", 80'(core_features), 80'(q[0].feat));
      if (act && (k >= R + 1))
        check("out_fields", 80'({out_class, out_tag, out_err}),
              80'({q[0].pred, q[0].tag, (q[0].pred >= 4'(CLS))}));
      check("done_cnt", 80'(done_cnt), 80'(done_m));
`ifdef BNN_ROLL_SCHED_PERF_EN
      check("busy_cycles", 80'(busy_cycles), 80'(busy_m));
`else
      check("busy_cycles", 80'(busy_cycles), 80'(0));
`endif
      if (act && (k == R)) done_m = done_m + 16'd1;
      if (act && (busy_m != 32'hFFFF_FFFF)) busy_m = busy_m + 32'd1;
      if (act && (k >= R + 1) && out_ready) void'(q.pop_front());
    end
  end

  task automatic send(input logic [7:0] tag, input logic [3:0] pred, input bit keep, input bit gapchk);
    int          n;
    logic [63:0] f;
    f           = {$urandom, $urandom};
    in_valid    = 1'b1;
    in_tag      = tag;
    in_features = f;
    n           = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 80'(0), 80'(1));
      in_valid = 1'b0;
      return;
    end
    q.push_back('{tag: tag, pred: pred, feat: f, acc: cyc + 1});
    if (gapchk) check("b2b_gap", 80'(cyc + 1 - last_acc), 80'(R + 3));
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    core_prediction = pred;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) check("valid_timeout", 80'(0), 80'(1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Abort in the middle of RUN.
    ready_fix = 1'b1;
    send(8'h11, 4'd3, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_ctrl", 80'({core_rst, out_valid, done_cnt}), 80'({1'b1, 1'b0, 16'd0}));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 80'(in_ready), 80'(1));

    // Single sample after reset.
    send(8'h2A, 4'd7, 1'b0, 1'b0);
    wait_valid();
    check("single_result", 80'({out_class, out_tag, out_err}), 80'({4'd7, 8'h2A, 1'b0}));
    @(posedge clk);
    #1;
    check("single_done_cnt", 80'(done_cnt), 80'(1));

    // Five stall cycles from a fresh reset.
    do_reset();
    ready_fix = 1'b0;
    send(8'h33, 4'd2, 1'b0, 1'b0);
    wait_valid();
    repeat (5) @(posedge clk);
    #1;
    ready_fix = 1'b1;
    @(posedge clk);
    #1;
`ifdef BNN_ROLL_SCHED_PERF_EN
    check("perf_busy", 80'(busy_cycles), 80'(87));
`else
    check("perf_busy", 80'(busy_cycles), 80'(0));
`endif

    // Long backpressure.
    ready_fix = 1'b0;
    send(8'h44, 4'd9, 1'b0, 1'b0);
    wait_valid();
    repeat (20) @(posedge clk);
    #1;
    ready_fix = 1'b1;
    @(posedge clk);
    #3;
    check("bp_release", 80'({out_valid, in_ready}), 80'(2'b01));

    // Out-of-range prediction.
    send(8'h5C, 4'd12, 1'b0, 1'b0);
    wait_valid();
    check("err_flag", 80'({out_class, out_err}), 80'({4'd12, 1'b1}));
    @(posedge clk);
    #1;

    // Back-to-back with in_valid and out_ready held high.
    do_reset();
    send(8'hA1, 4'd1, 1'b1, 1'b0);
    send(8'hA2, 4'd5, 1'b1, 1'b1);
    send(8'hA3, 4'd8, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("b2b_done_cnt", 80'(done_cnt), 80'(3));

    // Randomized traffic with random consumer stalls.
    rnd_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(8'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    ready_fix = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check("queue_drained", 80'(q.size()), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
